spi_slave_byte: RTL

//  SPI mode-0 slave front end. It synchronises the SCK/SS/MOSI pads into clk, deserialises

---
 rtl/spi_slave_byte.sv | 124 ++++++++++++
 1 files changed

// File: rtl/spi_slave_byte.sv
// SPI mode-0 slave front end: pad synchronisers, MOSI deserialiser, MISO serialiser, frame pulses.
// Optional SPI_FRAME_ERR_EN adds frame_err, which flags a frame that ended on a partial word.
module spi_slave_byte #(
    parameter int SYNC_STAGES = 2,
    parameter int WORD_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_sck,
    input  logic              spi_ss,
    input  logic              spi_mosi,
    output logic              spi_miso,
    input  logic [WORD_W-1:0] tx_data,
    output logic              done,
    output logic [WORD_W-1:0] dout,
    output logic              frame_start,
`ifdef SPI_FRAME_ERR_EN
    output logic              frame_err,
`endif
    output logic              frame_end
);
    localparam int CNT_W = $clog2(WORD_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

    logic [SYNC_STAGES-1:0] sck_chain;
    logic [SYNC_STAGES-1:0] ss_chain;
    logic [SYNC_STAGES-1:0] mosi_chain;
    logic                   sck_hist;
    logic                   ss_hist;
    logic                   sck_sync;
    logic                   ss_sync;
    logic                   mosi_sync;
    logic                   sck_rise;
    logic                   sck_fall;
    logic                   ss_fall;
    logic                   ss_rise;
    logic                   active;
    logic                   word_last;
    logic [CNT_W-1:0]       bit_cnt;
    logic [WORD_W-2:0]      rx_shift;
    logic [WORD_W-1:0]      rx_next;
    logic [WORD_W-1:0]      tx_shift;

    assign sck_sync  = sck_chain[SYNC_STAGES-1];
    assign ss_sync   = ss_chain[SYNC_STAGES-1];
    assign mosi_sync = mosi_chain[SYNC_STAGES-1];

    assign sck_rise = sck_sync & ~sck_hist;
    assign sck_fall = ~sck_sync & sck_hist;
    assign ss_fall  = ~ss_sync & ss_hist;
    assign ss_rise  = ss_sync & ~ss_hist;

    // Gate on the previous SS sample so a last SCK edge that lands together with SS rising
    // still completes its word.
    assign active    = ~ss_hist;
    assign word_last = active & sck_rise & (bit_cnt == LAST_BIT);
    assign rx_next   = {rx_shift, mosi_sync};

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_chain   <= '0;
            ss_chain    <= '1;
            mosi_chain  <= '0;
            sck_hist    <= 1'b0;
            ss_hist     <= 1'b1;
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            spi_miso    <= 1'b0;
            done        <= 1'b0;
            dout        <= '0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
            frame_err   <= 1'b0;
`endif
        end else begin
            sck_chain   <= {sck_chain[SYNC_STAGES-2:0], spi_sck};
            ss_chain    <= {ss_chain[SYNC_STAGES-2:0], spi_ss};
            mosi_chain  <= {mosi_chain[SYNC_STAGES-2:0], spi_mosi};
            sck_hist    <= sck_sync;
            ss_hist     <= ss_sync;
            done        <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
            frame_err   <= 1'b0;
`endif
            spi_miso    <= ss_sync ? 1'b0 : tx_shift[WORD_W-1];

            if (active && sck_rise) begin
                rx_shift <= rx_next[WORD_W-2:0];
                bit_cnt  <= word_last ? '0 : bit_cnt + 1'b1;
                if (word_last) begin
                    done <= 1'b1;
                    dout <= rx_next;
                end
            end

            // bit_cnt==0 on a falling edge means a word boundary: fetch the next tx byte.
            if (active && sck_fall) begin
                if (bit_cnt == '0)
                    tx_shift <= tx_data;
                else
                    tx_shift <= {tx_shift[WORD_W-2:0], 1'b0};
            end

            if (ss_fall) begin
                frame_start <= 1'b1;
                tx_shift    <= tx_data;
                bit_cnt     <= '0;
            end

            if (ss_rise) begin
                frame_end <= 1'b1;
                bit_cnt   <= '0;
                tx_shift  <= '0;
`ifdef SPI_FRAME_ERR_EN
                frame_err <= (bit_cnt != '0) && !word_last;
`endif
            end
        end
    end
endmodule
